// File: rtl/arbitro_memoria_if.sv
// Request/grant bus shared by the fetch path, the load/store path and the
// single-port memory. The arbiter takes the slave view; requesters and the
// memory model drive from the master view.
interface arbitro_memoria_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
);
   logic              busca_req;
   logic [ADDR_W-1:0] busca_end;
   logic              busca_gnt;
   logic              busca_valid;
   logic [DATA_W-1:0] busca_dado;

   logic              dados_req;
   logic              dados_we;
   logic [ADDR_W-1:0] dados_end;
   logic [DATA_W-1:0] dados_wdata;
   logic              dados_gnt;
   logic              dados_valid;
   logic [DATA_W-1:0] dados_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  busca_req, busca_end,
      input  dados_req, dados_we, dados_end, dados_wdata,
      input  mem_rdata,
      output busca_gnt, busca_valid, busca_dado,
      output dados_gnt, dados_valid, dados_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output busca_req, busca_end,
      output dados_req, dados_we, dados_end, dados_wdata,
      output mem_rdata,
      input  busca_gnt, busca_valid, busca_dado,
      input  dados_gnt, dados_valid, dados_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/arbitro_memoria.sv
// Arbiter/sequencer for the unified single-port memory. Load/store (dados)
// wins over fetch (busca) until MAX_SEQ consecutive dados grants have been
// given while fetch waits; then fetch gets one slot. One access in flight.
module arbitro_memoria #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 2,
   parameter int MAX_SEQ = 3
) (
   input logic                clk,
   input logic                rst_n,
   arbitro_memoria_if.slave   bus
);
   typedef enum logic [1:0] {LIVRE, ESPERA, ENTREGA} estado_t;

   localparam logic [2:0] CNT_INI = 3'(MEM_LAT - 1);
   localparam logic [2:0] SEQ_LIM = 3'(MAX_SEQ);

   estado_t           estado_q;
   logic [2:0]        cnt_q;
   logic [2:0]        seq_q;
   logic              dono_q;      // 1 = outstanding read belongs to dados
   logic              busca_valid_q;
   logic              dados_valid_q;
   logic [DATA_W-1:0] busca_dado_q;
   logic [DATA_W-1:0] dados_rdata_q;

   logic              arb_ok;
   logic              dados_win;
   logic              busca_win;

   // Winner selection; gated by reset so no grant leaks out while in reset.
   always_comb begin
      arb_ok    = rst_n && (estado_q != ESPERA);
      dados_win = arb_ok && bus.dados_req &&
                  !((seq_q == SEQ_LIM) && bus.busca_req);
      busca_win = arb_ok && bus.busca_req && !dados_win;
   end

   assign bus.busca_gnt   = busca_win;
   assign bus.dados_gnt   = dados_win;
   assign bus.mem_en      = busca_win | dados_win;
   assign bus.mem_we      = dados_win & bus.dados_we;
   assign bus.mem_addr    = dados_win ? bus.dados_end :
                            busca_win ? bus.busca_end : '0;
   assign bus.mem_wdata   = (dados_win && bus.dados_we) ? bus.dados_wdata : '0;
   assign bus.busca_valid = busca_valid_q;
   assign bus.dados_valid = dados_valid_q;
   assign bus.busca_dado  = busca_dado_q;
   assign bus.dados_rdata = dados_rdata_q;

   // Sequencer FSM: latency tracking, read data capture, valid pulses, fairness counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         estado_q      <= LIVRE;
         cnt_q         <= '0;
         seq_q         <= '0;
         dono_q        <= 1'b0;
         busca_valid_q <= 1'b0;
         dados_valid_q <= 1'b0;
         busca_dado_q  <= '0;
         dados_rdata_q <= '0;
      end else begin
         busca_valid_q <= 1'b0;
         dados_valid_q <= 1'b0;

         // Fairness: count dados grants only while fetch is actually waiting.
         if (!bus.busca_req || busca_win)
            seq_q <= '0;
         else if (dados_win && (seq_q != SEQ_LIM))
            seq_q <= seq_q + 3'd1;

         case (estado_q)
            ESPERA: begin
               if (cnt_q == 3'd0) begin
                  if (dono_q) begin
                     dados_rdata_q <= bus.mem_rdata;
                     dados_valid_q <= 1'b1;
                  end else begin
                     busca_dado_q  <= bus.mem_rdata;
                     busca_valid_q <= 1'b1;
                  end
                  estado_q <= ENTREGA;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            default: begin
               // LIVRE and ENTREGA both arbitrate; ENTREGA overlaps the next grant.
               if (dados_win && bus.dados_we) begin
                  dados_valid_q <= 1'b1;
                  estado_q      <= LIVRE;
               end else if (dados_win || busca_win) begin
                  estado_q <= ESPERA;
                  cnt_q    <= CNT_INI;
                  dono_q   <= dados_win;
               end else begin
                  estado_q <= LIVRE;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria: reset, fetch, write/read, fairness,
// contention during a pending read, reset during a pending read.
module tb_arbitro_memoria;
   localparam int AW  = 8;
   localparam int DW  = 16;
   localparam int LAT = 2;
   localparam int MSQ = 3;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_fail = 0;

   arbitro_memoria_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   arbitro_memoria #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_SEQ(MSQ)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Memory model: data for an access at T appears on mem_rdata at T+LAT.
   logic [DW-1:0] mem_arr [0:255];
   logic [DW-1:0] rd_pipe [0:3];

   always @(posedge clk) begin
      if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr] <= bus.mem_wdata;
      rd_pipe[0] <= mem_arr[bus.mem_addr];
      for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign bus.mem_rdata = rd_pipe[LAT-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Move to the next cycle; inputs are then changed and outputs checked mid-cycle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic gnts(input string tag, input logic b, input logic d);
      chk({tag, "_busca_gnt"}, 32'(bus.busca_gnt), 32'(b));
      chk({tag, "_dados_gnt"}, 32'(bus.dados_gnt), 32'(d));
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem_arr[i] = 16'(i);
      for (int i = 0; i < 4; i++) rd_pipe[i] = '0;
      mem_arr[8'h10] = 16'hABCD;
      mem_arr[8'h11] = 16'hBEEF;

      // Reset with both requests high.
      rst_n = 1'b0;
      bus.busca_req = 1'b1; bus.busca_end = 8'h00;
      bus.dados_req = 1'b1; bus.dados_we = 1'b1;
      bus.dados_end = 8'h05; bus.dados_wdata = 16'h5555;
      tick();
      gnts("rst1", 1'b0, 1'b0);
      chk("rst1_mem_en", 32'(bus.mem_en), 0);
      tick();
      gnts("rst2", 1'b0, 1'b0);
      chk("rst2_mem_en", 32'(bus.mem_en), 0);
      chk("rst2_mem_addr", 32'(bus.mem_addr), 0);
      chk("rst2_bvalid", 32'(bus.busca_valid), 0);
      chk("rst2_dvalid", 32'(bus.dados_valid), 0);
      chk("rst2_bdado", 32'(bus.busca_dado), 0);
      chk("rst2_drdata", 32'(bus.dados_rdata), 0);
      rst_n = 1'b1;
      #1;
      gnts("rst_rel", 1'b0, 1'b1);
      tick();
      bus.dados_req = 1'b0;
      #1;
      chk("rst_wr_dvalid", 32'(bus.dados_valid), 1);
      gnts("rst_fetch", 1'b1, 1'b0);
      tick();
      bus.busca_req = 1'b0;
      tick(); tick(); tick();

      // Single fetch from 0x10.
      bus.busca_req = 1'b1; bus.busca_end = 8'h10;
      #1;
      gnts("f_T", 1'b1, 1'b0);
      chk("f_mem_en", 32'(bus.mem_en), 1);
      chk("f_mem_addr", 32'(bus.mem_addr), 32'h10);
      chk("f_mem_we", 32'(bus.mem_we), 0);
      tick();
      bus.busca_req = 1'b0;
      #1;
      chk("f_T1_bvalid", 32'(bus.busca_valid), 0);
      chk("f_T1_mem_en", 32'(bus.mem_en), 0);
      tick();
      chk("f_T2_bvalid", 32'(bus.busca_valid), 0);
      tick();
      chk("f_T3_bvalid", 32'(bus.busca_valid), 1);
      chk("f_T3_bdado", 32'(bus.busca_dado), 32'hABCD);
      tick();
      chk("f_T4_bvalid", 32'(bus.busca_valid), 0);
      chk("f_T4_bdado_hold", 32'(bus.busca_dado), 32'hABCD);

      // Write 0x1234 to 0x20, then read it back.
      bus.dados_req = 1'b1; bus.dados_we = 1'b1;
      bus.dados_end = 8'h20; bus.dados_wdata = 16'h1234;
      #1;
      gnts("wr_T", 1'b0, 1'b1);
      chk("wr_mem_we", 32'(bus.mem_we), 1);
      chk("wr_mem_wdata", 32'(bus.mem_wdata), 32'h1234);
      chk("wr_mem_addr", 32'(bus.mem_addr), 32'h20);
      tick();
      bus.dados_we = 1'b0;
      #1;
      chk("wr_T1_dvalid", 32'(bus.dados_valid), 1);
      chk("wr_T1_drdata_hold", 32'(bus.dados_rdata), 0);
      gnts("rd_T1", 1'b0, 1'b1);
      chk("rd_mem_we", 32'(bus.mem_we), 0);
      tick();
      bus.dados_req = 1'b0;
      #1;
      chk("rd_T2_dvalid", 32'(bus.dados_valid), 0);
      tick();
      chk("rd_T3_dvalid", 32'(bus.dados_valid), 0);
      tick();
      chk("rd_T4_dvalid", 32'(bus.dados_valid), 1);
      chk("rd_T4_drdata", 32'(bus.dados_rdata), 32'h1234);
      chk("rd_T4_bvalid", 32'(bus.busca_valid), 0);
      tick();

      // Fairness: both requests held, dados writing.
      bus.busca_req = 1'b1; bus.busca_end = 8'h11;
      bus.dados_req = 1'b1; bus.dados_we = 1'b1;
      bus.dados_end = 8'h30; bus.dados_wdata = 16'h0001;
      #1;
      gnts("sv_g0", 1'b0, 1'b1);
      tick();
      gnts("sv_g1", 1'b0, 1'b1);
      tick();
      gnts("sv_g2", 1'b0, 1'b1);
      tick();
      gnts("sv_g3", 1'b1, 1'b0);
      chk("sv_g3_addr", 32'(bus.mem_addr), 32'h11);
      tick();
      bus.busca_req = 1'b0;
      #1;
      gnts("sv_esp1", 1'b0, 1'b0);
      tick();
      gnts("sv_esp2", 1'b0, 1'b0);
      tick();
      chk("sv_bvalid", 32'(bus.busca_valid), 1);
      chk("sv_bdado", 32'(bus.busca_dado), 32'hBEEF);
      gnts("sv_g4", 1'b0, 1'b1);
      tick();
      bus.busca_req = 1'b1; bus.busca_end = 8'h10;
      #1;
      gnts("sv_g5", 1'b0, 1'b1);
      tick();
      bus.dados_req = 1'b0;
      #1;
      gnts("sv_g6", 1'b1, 1'b0);
      tick();
      bus.busca_req = 1'b0;
      tick(); tick(); tick();

      // Contention: dados arrives while a fetch is outstanding.
      bus.busca_req = 1'b1; bus.busca_end = 8'h10;
      #1;
      gnts("ct_T", 1'b1, 1'b0);
      tick();
      bus.busca_req = 1'b0;
      bus.dados_req = 1'b1; bus.dados_we = 1'b0; bus.dados_end = 8'h20;
      #1;
      gnts("ct_T1", 1'b0, 1'b0);
      tick();
      gnts("ct_T2", 1'b0, 1'b0);
      tick();
      gnts("ct_T3", 1'b0, 1'b1);
      chk("ct_T3_bvalid", 32'(bus.busca_valid), 1);
      chk("ct_T3_bdado", 32'(bus.busca_dado), 32'hABCD);
      tick();
      bus.dados_req = 1'b0;
      tick(); tick();
      chk("ct_T6_dvalid", 32'(bus.dados_valid), 1);
      chk("ct_T6_drdata", 32'(bus.dados_rdata), 32'h1234);
      tick();

      // Reset during an outstanding read.
      bus.busca_req = 1'b1; bus.busca_end = 8'h11;
      #1;
      gnts("rm_T", 1'b1, 1'b0);
      tick();
      bus.busca_req = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk($sformatf("rm_noval%0d", i), 32'(bus.busca_valid), 0);
         tick();
      end
      chk("rm_bdado_clr", 32'(bus.busca_dado), 0);
      bus.busca_req = 1'b1; bus.busca_end = 8'h10;
      #1;
      gnts("rm_new", 1'b1, 1'b0);
      tick();
      bus.busca_req = 1'b0;
      tick(); tick();
      chk("rm_new_bvalid", 32'(bus.busca_valid), 1);
      chk("rm_new_bdado", 32'(bus.busca_dado), 32'hABCD);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/arbitro_memoria.md
# arbitro_memoria

Arbiter and sequencer sharing the single-port unified memory between the instruction-fetch path (busca) and the load/store path (dados) of the multicycle processor. It grants one access per free slot and drives the memory port. It tracks the fixed memory read latency and returns read data or a write acknowledge to the requester that owns the access. Data accesses have priority, bounded by an anti-starvation limit so fetch always progresses.

## Interface
- ADDR_W, 8, address width
- DATA_W, 16, data width
- MEM_LAT, 2, memory read latency in cycles (legal 1..4)
- MAX_SEQ, 3, max consecutive dados grants while busca_req is pending (legal 1..7)

Ports. One clock; reset is synchronous and active-low.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- busca_req  in  1  fetch request, level, held until busca_gnt
- busca_end  in  ADDR_W  fetch address
- busca_gnt  out  1  fetch granted this cycle
- busca_valid  out  1  one-cycle pulse, busca_dado valid
- busca_dado  out  DATA_W  fetched word
- dados_req  in  1  data request, level, held until dados_gnt
- dados_we  in  1  1 = write, 0 = read
- dados_end  in  ADDR_W  data address
- dados_wdata  in  DATA_W  write data
- dados_gnt  out  1  data access granted this cycle
- dados_valid  out  1  one-cycle pulse: read data valid, or write done
- dados_rdata  out  DATA_W  read word
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after mem_en

## Operation
- States: LIVRE (port free), ESPERA (read outstanding, latency counter running), ENTREGA (read data registered, valid pulse).
- Arbitration happens in LIVRE and ENTREGA. Winner:
  - dados if dados_req=1, unless seq_cnt==MAX_SEQ and busca_req=1.
  - otherwise busca if busca_req=1.
- Grant cycle: gnt=1 for the winner, mem_en=1, mem_addr/mem_we/mem_wdata come from the winner. Busca is always a read. This is combinational from state and req in the same cycle.
- mem_addr, mem_wdata and mem_we are 0 whenever mem_en=0.
- Read grant: go to ESPERA, load cnt=MEM_LAT-1, record owner. When cnt reaches 0, capture mem_rdata into the owner's data register and go to ENTREGA.
- Write grant: stays arbitrating. dados_valid pulses in the next cycle and dados_rdata is unchanged.
- seq_cnt (3 bits) updates per grant:
  - increments on a dados grant while busca_req=1, saturating at MAX_SEQ.
  - clears on a busca grant, or in any cycle with busca_req=0.
- A requester must deassert req in the cycle after its gnt unless it issues a new request. req held high in that cycle is a new request.
- busca_dado and dados_rdata hold their last value between pulses.

## Timing
- Reset (rst_n=0 at a rising edge): state LIVRE, seq_cnt=0, cnt=0, all outputs 0 including data registers.
  - An outstanding read is discarded; no valid is issued after reset.
  - Reset dominates any grant in the same cycle.
- Read: gnt and mem_en in cycle T. The memory presents data in T+MEM_LAT. valid plus data in T+MEM_LAT+1. The next grant is possible in T+MEM_LAT+1 (back-to-back, overlapping ENTREGA).
- Read throughput: one read per MEM_LAT+1 cycles.
- Write: gnt and mem_en in T, dados_valid in T+1. The next grant is possible in T+1, so writes run at 1 per cycle.
- No gnt is issued in ESPERA. Requests stay pending, no loss.
- Simultaneous busca_req and dados_req with seq_cnt<MAX_SEQ: dados wins.
- Never more than one gnt per cycle. Never more than one access outstanding.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with both req=1 -> all outputs 0, no gnt. After release, dados_gnt is the first grant.
- Single fetch, MEM_LAT=2: busca_req with busca_end=0x10 at T, memory returns 0xABCD -> busca_gnt and mem_en at T, mem_addr=0x10, busca_valid=1 with busca_dado=0xABCD at T+3.
- Write then read, same address 0x20: write 0x1234, then read -> dados_valid at T+1 for the write, second gnt at T+1, read returns 0x1234 with dados_valid at T+4.
- Starvation, MAX_SEQ=3: busca_req and dados_req held high, dados doing writes -> grants in order dados, dados, dados, busca, dados...; seq_cnt clears after the busca grant.
- Contention during ESPERA: busca read outstanding, dados_req rises at T+1 -> no gnt at T+1..T+2; dados_gnt at T+3, the same cycle as busca_valid.
- Reset mid-read: rst_n=0 at T+1 after a read grant at T -> no busca_valid ever. State returns to LIVRE and the next request is granted normally.
